// File: rtl/ex_muldiv_iter.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One result bit per cycle; divide-by-zero and signed overflow take a 1-cycle fast path.
module ex_muldiv_iter #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            valid_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;     // {hi, lo}: product, or {remainder, quotient}
   logic [XLEN-1:0]     mag_b_q, mag_b_d;
   logic [2:0]          f3_q, f3_d;
   logic                neg_q, neg_d;     // operand signs differ
   logic                sgn_a_q, sgn_a_d; // remainder sign
   logic [XLEN-1:0]     result_q, result_d;
   logic [4:0]          rd_q, rd_d;

   // Operand decode at accept
   logic            in_div, a_signed, b_signed, sign_a, sign_b;
   logic [XLEN-1:0] abs_a, abs_b;
   logic            div_zero, div_ovf;

   assign in_div   = funct3_i[2];
   assign a_signed = in_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
   assign b_signed = in_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
   assign sign_a   = a_signed & op_a_i[XLEN-1];
   assign sign_b   = b_signed & op_b_i[XLEN-1];
   assign abs_a    = sign_a ? ({XLEN{1'b0}} - op_a_i) : op_a_i;
   assign abs_b    = sign_b ? ({XLEN{1'b0}} - op_b_i) : op_b_i;
   assign div_zero = in_div && (op_b_i == '0);
   assign div_ovf  = in_div && !funct3_i[0] && (op_a_i == MinInt) && (op_b_i == '1);

   // Iteration datapath
   logic [XLEN:0]     mul_sum, div_trial, div_diff;
   logic [2*XLEN-1:0] mul_next, div_next;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix;

   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
   assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
   assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_diff  = div_trial - {1'b0, mag_b_q};
   // A clear borrow bit means the trial remainder covers the divisor
   assign div_next  = div_diff[XLEN]
                    ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

   assign prod_fix = neg_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
   assign quot_fix = neg_q ? ({XLEN{1'b0}} - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
   assign rem_fix  = sgn_a_q ? ({XLEN{1'b0}} - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

   // Next-state, iteration and result selection
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mag_b_d  = mag_b_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      sgn_a_d  = sgn_a_q;
      result_d = result_q;
      rd_d     = rd_q;

      unique case (state_q)
         StIdle: begin
            if (valid_i && !flush_i) begin
               f3_d    = funct3_i;
               rd_d    = rd_i;
               mag_b_d = abs_b;
               neg_d   = sign_a ^ sign_b;
               sgn_a_d = sign_a;
               if (div_zero) begin
                  result_d = funct3_i[1] ? op_a_i : '1;
                  state_d  = StDone;
               end else if (div_ovf) begin
                  result_d = funct3_i[1] ? '0 : MinInt;
                  state_d  = StDone;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, abs_a};
                  cnt_d   = CNT_W'(XLEN);
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            acc_d = f3_q[2] ? div_next : mul_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = StFix;
         end
         StFix: begin
            case (f3_q)
               3'b000:                 result_d = prod_fix[XLEN-1:0];
               3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
               3'b100, 3'b101:         result_d = quot_fix;
               default:                result_d = rem_fix;
            endcase
            state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // A flush abandons the op and leaves the previous result in place
      if (flush_i) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         mag_b_q  <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         sgn_a_q  <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mag_b_q  <= mag_b_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         sgn_a_q  <= sgn_a_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

   assign stall_o  = ((state_q == StIdle) && valid_i && !flush_i) ||
                     (state_q == StCalc) || (state_q == StFix);
   assign busy_o   = (state_q != StIdle);
   assign done_o   = (state_q == StDone) && !flush_i;
   assign result_o = result_q;
   assign rd_o     = rd_q;

endmodule
